uart_cmd_decoder: RTL

Command stage directly downstream of the UART receiver: buffers received bytes in a small FIFO and decodes ASCII commands into single-cycle control pulses and an edit-field select for the stopwatch/watch control unit. It sits between `uart_rx` and the control unit. Its pulses are OR-ed with the debounced button pulses (btnL_RunStop, btnR_Clear, btnU, btnD, mode), so UART and board buttons drive identical actions. Optionally it echoes each accepted byte back through `uart_tx`.

---
 rtl/cmd_pkg.sv | 93 +++++++++
 rtl/cmd_fifo.sv | 57 +++++
 rtl/uart_cmd_decoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// cmd_pkg: shared definitions for the UART command decoder.
//   - ASCII codes of the recognised command bytes (upper case) plus CR/LF
//   - o_sel encoding (sel_e)
//   - decoder FSM state enum (state_e); echo states are used only when
//     UART_CMD_ECHO_EN is defined
//   - decode_byte(): maps one received byte to an action/select/error record
package cmd_pkg;

  localparam logic [7:0] ASCII_M  = 8'h4D;
  localparam logic [7:0] ASCII_G  = 8'h47;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_U  = 8'h55;
  localparam logic [7:0] ASCII_D  = 8'h44;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_2  = 8'h32;
  localparam logic [7:0] ASCII_3  = 8'h33;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_HOUR = 2'd1,
    SEL_MIN  = 2'd2,
    SEL_SEC  = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StEchoReq,
    StEchoWait
  } state_e;

  typedef enum logic [2:0] {
    ActNone,
    ActMode,
    ActRunStop,
    ActClear,
    ActUp,
    ActDown
  } act_e;

  typedef struct packed {
    act_e act;     // pulse to fire
    logic sel_wr;  // o_sel is rewritten with sel
    sel_e sel;
    logic err;     // unrecognised byte
    logic ignore;  // CR/LF: no pulse, no error, no echo
  } cmd_t;

  function automatic cmd_t decode_byte(input logic [7:0] b);
    logic [7:0] u;
    cmd_t       c;
    // Fold a-z onto A-Z so letter commands are case-insensitive
    u = b;
    if (b >= 8'h61 && b <= 8'h7A) begin
      u = b - 8'h20;
    end
    c = '{act: ActNone, sel_wr: 1'b0, sel: SEL_NONE, err: 1'b0, ignore: 1'b0};
    case (u)
      ASCII_M: begin
        c.act    = ActMode;
        c.sel_wr = 1'b1;
        c.sel    = SEL_NONE;
      end
      ASCII_G:  c.act = ActRunStop;
      ASCII_C:  c.act = ActClear;
      ASCII_U:  c.act = ActUp;
      ASCII_D:  c.act = ActDown;
      ASCII_0: begin
        c.sel_wr = 1'b1;
        c.sel    = SEL_NONE;
      end
      ASCII_1: begin
        c.sel_wr = 1'b1;
        c.sel    = SEL_HOUR;
      end
      ASCII_2: begin
        c.sel_wr = 1'b1;
        c.sel    = SEL_MIN;
      end
      ASCII_3: begin
        c.sel_wr = 1'b1;
        c.sel    = SEL_SEC;
      end
      ASCII_CR, ASCII_LF: c.ignore = 1'b1;
      default:  c.err = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous first-word-fall-through byte FIFO.
//   clk, reset (async, active low)
//   push/wr_data : write request; accepted when not full, or when a pop
//                  happens in the same cycle
//   pop/rd_data  : read request; rd_data shows the head entry while !empty
//   full, empty  : occupancy flags
// FIFO_DEPTH must be a power of two and at least 2.
module cmd_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wr_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CntFull = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CntFull);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  // Full is judged after the same-cycle pop, so push+pop while full succeeds
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: buffers bytes from uart_rx and decodes ASCII commands into
// single-cycle control pulses and an edit-field select.
//   clk, reset (async, active low)
//   rx_data/rx_done : received byte and its one-cycle strobe
//   tx_busy         : uart_tx transmitting
//   tx_start/tx_data: echo request and byte (tied to 0 without echo)
//   o_mode_tgl, o_run_stop, o_clear, o_up, o_down : one-cycle action pulses
//   o_sel           : edit field 0 none, 1 hour, 2 min, 3 sec
//   o_err_cnt       : unrecognised bytes, saturating
//   o_drop_cnt      : bytes lost to a full FIFO, saturating
// Define UART_CMD_ECHO_EN to echo every non-CR/LF byte through uart_tx.
module uart_cmd_decoder
  import cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       o_mode_tgl,
  output logic       o_run_stop,
  output logic       o_clear,
  output logic       o_up,
  output logic       o_down,
  output logic [1:0] o_sel,
  output logic [7:0] o_err_cnt,
  output logic [7:0] o_drop_cnt
);

  state_e     state_q, state_d;
  logic [7:0] hold_q;
  logic [7:0] fifo_rd_data;
  logic       fifo_full, fifo_empty, fifo_pop;
  logic       decode_en, drop;
  cmd_t       cmd;

  logic       mode_q, run_q, clear_q, up_q, down_q;
  sel_e       sel_q;
  logic [7:0] err_cnt_q, drop_cnt_q;

  cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (rx_done),
    .wr_data(rx_data),
    .pop    (fifo_pop),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign cmd  = decode_byte(hold_q);
  assign drop = rx_done && fifo_full && !fifo_pop;

`ifdef UART_CMD_ECHO_EN
  logic echo_start;
  logic seen_busy_q, seen_busy_d;
`else
  logic unused_echo;
  assign unused_echo = ^{tx_busy, cmd.ignore};
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (!fifo_empty) state_d = StDecode;
`ifdef UART_CMD_ECHO_EN
      StDecode:   state_d = cmd.ignore ? StIdle : StEchoReq;
      StEchoReq:  if (!tx_busy) state_d = StEchoWait;
      StEchoWait: if (seen_busy_q && !tx_busy) state_d = StIdle;
`else
      StDecode: state_d = StIdle;
`endif
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    fifo_pop  = 1'b0;
    decode_en = 1'b0;
`ifdef UART_CMD_ECHO_EN
    echo_start = 1'b0;
`endif
    case (state_q)
      StIdle:    fifo_pop = !fifo_empty;
      StDecode:  decode_en = 1'b1;
`ifdef UART_CMD_ECHO_EN
      StEchoReq: echo_start = !tx_busy;
`endif
      default:   ;
    endcase
  end

`ifdef UART_CMD_ECHO_EN
  // Leave ECHO_WAIT only after the transmitter has been seen busy, so a slow
  // tx_busy rise cannot end the echo early
  assign seen_busy_d = (state_q == StEchoWait) && (state_d == StEchoWait) &&
                       (seen_busy_q || tx_busy);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_busy_q <= 1'b0;
    end else begin
      seen_busy_q <= seen_busy_d;
    end
  end

  assign tx_start = echo_start;
  assign tx_data  = hold_q;
`else
  assign tx_start = 1'b0;
  assign tx_data  = 8'h00;
`endif

  // Holding register; stays stable through any echo until the next pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= 8'h00;
    end else if (fifo_pop) begin
      hold_q <= fifo_rd_data;
    end
  end

  // Action pulses, field select and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q     <= 1'b0;
      run_q      <= 1'b0;
      clear_q    <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      sel_q      <= SEL_NONE;
      err_cnt_q  <= 8'h00;
      drop_cnt_q <= 8'h00;
    end else begin
      mode_q  <= decode_en && (cmd.act == ActMode);
      run_q   <= decode_en && (cmd.act == ActRunStop);
      clear_q <= decode_en && (cmd.act == ActClear);
      up_q    <= decode_en && (cmd.act == ActUp);
      down_q  <= decode_en && (cmd.act == ActDown);
      if (decode_en && cmd.sel_wr) begin
        sel_q <= cmd.sel;
      end
      if (decode_en && cmd.err && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
      if (drop && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign o_mode_tgl = mode_q;
  assign o_run_stop = run_q;
  assign o_clear    = clear_q;
  assign o_up       = up_q;
  assign o_down     = down_q;
  assign o_sel      = sel_q;
  assign o_err_cnt  = err_cnt_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule
